// File: rtl/pd_mem_pkg.sv
// Shared types and grant helper for the unified memory port arbiter.
package pd_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  // On a tie the port that did not win last time is chosen; passing
  // last = OWN_FETCH permanently turns this into data-over-fetch priority.
  function automatic arb_owner_t pick_owner(input logic if_v, input logic d_v,
                                            input arb_owner_t last);
    arb_owner_t win;
    if (if_v && d_v) begin
      win = (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else begin
      win = d_v ? OWN_DATA : OWN_FETCH;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bus of the fetch/data memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  // Handshake rule for every req channel: a transfer happens on the rising
  // edge where valid and ready are both high; the requester holds valid and
  // payload until then, ready never depends on anything but state and valid.
  logic                  if_req_valid;
  logic [AWIDTH-1:0]     if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DWIDTH-1:0]     if_rsp_data;
  logic                  d_req_valid;
  logic [AWIDTH-1:0]     d_req_addr;
  logic                  d_req_we;
  logic [DWIDTH-1:0]     d_req_wdata;
  logic [DWIDTH/8-1:0]   d_req_wstrb;
  logic                  d_req_ready;
  logic                  d_rsp_valid;
  logic [DWIDTH-1:0]     d_rsp_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [AWIDTH-1:0]     mem_addr;
  logic                  mem_we;
  logic [DWIDTH-1:0]     mem_wdata;
  logic [DWIDTH/8-1:0]   mem_wstrb;
  logic                  mem_rsp_valid;
  logic [DWIDTH-1:0]     mem_rsp_data;

  // Pipeline stages and memory model drive from this side.
  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  // The arbiter's view.
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise data beats fetch.
module mem_port_arbiter
  import pd_mem_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output arb_state_t         dbg_state,
  output arb_owner_t         dbg_owner
);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [DWIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic [DWIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                  if_rsp_valid_q, if_rsp_valid_d;
  logic                  d_rsp_valid_q, d_rsp_valid_d;

  arb_owner_t            last_grant;
  arb_owner_t            grant;
  logic                  accept_ok;
  logic                  if_ready;
  logic                  d_ready;

`ifdef MEM_ARB_RR_EN
  arb_owner_t            last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_FETCH;
`endif

  assign grant     = pick_owner(bus.if_req_valid, bus.d_req_valid, last_grant);
  // The response pulse cycle is already IDLE, but a new grant waits one cycle.
  assign accept_ok = (state_q == IDLE) && !if_rsp_valid_q && !d_rsp_valid_q;
  assign if_ready  = accept_ok && bus.if_req_valid && (grant == OWN_FETCH);
  assign d_ready   = accept_ok && bus.d_req_valid && (grant == OWN_DATA);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    rsp_data_d     = rsp_data_q;
    if_rsp_valid_d = 1'b0;
    d_rsp_valid_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_ready) begin
          owner_d = OWN_DATA;
          addr_d  = bus.d_req_addr;
          we_d    = bus.d_req_we;
          wdata_d = bus.d_req_wdata;
          wstrb_d = bus.d_req_we ? bus.d_req_wstrb : '0;
          state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
          last_grant_d = OWN_DATA;
`endif
        end else if (if_ready) begin
          owner_d = OWN_FETCH;
          addr_d  = bus.if_req_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
          last_grant_d = OWN_FETCH;
`endif
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          rsp_data_d     = bus.mem_rsp_data;
          if_rsp_valid_d = (owner_q == OWN_FETCH);
          d_rsp_valid_d  = (owner_q == OWN_DATA);
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWN_FETCH;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rsp_data_q     <= '0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q   <= OWN_FETCH;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      rsp_data_q     <= rsp_data_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign bus.if_req_ready  = if_ready;
  assign bus.d_req_ready   = d_ready;
  assign bus.if_rsp_valid  = if_rsp_valid_q;
  assign bus.d_rsp_valid   = d_rsp_valid_q;
  assign bus.if_rsp_data   = rsp_data_q;
  assign bus.d_rsp_data    = rsp_data_q;
  assign bus.mem_req_valid = (state_q == ISSUE);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wstrb     = wstrb_q;
  assign dbg_state         = state_q;
  assign dbg_owner         = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, hold, reset and stray responses.
module tb_mem_port_arbiter;
  import pd_mem_pkg::*;

  logic       clk;
  logic       reset;
  arb_state_t dbg_state;
  arb_owner_t dbg_owner;
  int         chk_cnt;
  int         pass_cnt;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_owner (dbg_owner)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_valid  = 1'b0;
    bus.if_req_addr   = '0;
    bus.d_req_valid   = 1'b0;
    bus.d_req_addr    = '0;
    bus.d_req_we      = 1'b0;
    bus.d_req_wdata   = '0;
    bus.d_req_wstrb   = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) tick();
    @(negedge clk);
    chk_cnt++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
    chk_cnt++;
    if ({bus.if_req_ready, bus.if_rsp_valid, bus.if_rsp_data, bus.d_req_ready, bus.d_rsp_valid,
         bus.d_rsp_data, bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !== '0)
      $display("FAIL reset_outputs: got nonzero want all 0");
    else pass_cnt++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0100_0000; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (bus.if_req_ready !== 1'b1) $display("FAIL fetch_ready_T: got %0b want 1", bus.if_req_ready); else pass_cnt++;
    chk_cnt++; if (bus.mem_req_valid !== 1'b0) $display("FAIL fetch_noreq_T: got %0b want 0", bus.mem_req_valid); else pass_cnt++;
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.mem_req_valid !== 1'b1) $display("FAIL fetch_req_T1: got %0b want 1", bus.mem_req_valid); else pass_cnt++;
    chk_cnt++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_wstrb} !== {32'h0100_0000, 1'b0, 4'h0})
      $display("FAIL fetch_payload: got %h/%0b/%h want 01000000/0/0", bus.mem_addr, bus.mem_we, bus.mem_wstrb);
    else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0013;
    @(negedge clk);
    chk_cnt++; if ({bus.if_rsp_valid, bus.mem_req_valid} !== 2'b00) $display("FAIL fetch_T2: got %b want 00", {bus.if_rsp_valid, bus.mem_req_valid}); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    @(negedge clk);
    chk_cnt++; if (bus.if_rsp_valid !== 1'b1) $display("FAIL fetch_rsp_T3: got %0b want 1", bus.if_rsp_valid); else pass_cnt++;
    chk_cnt++; if (bus.if_rsp_data !== 32'h0000_0013) $display("FAIL fetch_rsp_data: got %h want 00000013", bus.if_rsp_data); else pass_cnt++;
    chk_cnt++; if (bus.d_rsp_valid !== 1'b0) $display("FAIL fetch_no_drsp: got %0b want 0", bus.d_rsp_valid); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.if_rsp_valid !== 1'b0) $display("FAIL fetch_pulse_len: got %0b want 0", bus.if_rsp_valid); else pass_cnt++;
  endtask

  task automatic test_priority();
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0100_0004;
    bus.d_req_valid  = 1'b1; bus.d_req_addr  = 32'h0100_0100; bus.d_req_we = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.d_req_ready, bus.if_req_ready} !== 2'b10) $display("FAIL prio_grant: got %b want 10", {bus.d_req_ready, bus.if_req_ready}); else pass_cnt++;
    tick();
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.mem_addr !== 32'h0100_0100) $display("FAIL prio_addr_d: got %h want 01000100", bus.mem_addr); else pass_cnt++;
    chk_cnt++; if (bus.if_req_ready !== 1'b0) $display("FAIL prio_busy_ready: got %0b want 0", bus.if_req_ready); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hCAFE_0001;
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.d_rsp_valid, bus.if_rsp_valid} !== 2'b10) $display("FAIL prio_rsp_d: got %b want 10", {bus.d_rsp_valid, bus.if_rsp_valid}); else pass_cnt++;
    chk_cnt++; if (bus.d_rsp_data !== 32'hCAFE_0001) $display("FAIL prio_rsp_data: got %h want cafe0001", bus.d_rsp_data); else pass_cnt++;
    chk_cnt++; if (bus.if_req_ready !== 1'b0) $display("FAIL prio_pulse_block: got %0b want 0", bus.if_req_ready); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.if_req_ready !== 1'b1) $display("FAIL prio_fetch_next: got %0b want 1", bus.if_req_ready); else pass_cnt++;
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, 32'h0100_0004}) $display("FAIL prio_addr_f: got %h want 01000004", bus.mem_addr); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0093;
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b1, 32'h0000_0093}) $display("FAIL prio_rsp_f: got %0b/%h want 1/00000093", bus.if_rsp_valid, bus.if_rsp_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_store_hold();
    bus.mem_req_ready = 1'b0;
    tick();
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h0100_0200;
    bus.d_req_wdata = 32'hDEAD_BEEF; bus.d_req_wstrb = 4'b0011;
    @(negedge clk);
    chk_cnt++; if (bus.d_req_ready !== 1'b1) $display("FAIL store_ready: got %0b want 1", bus.d_req_ready); else pass_cnt++;
    tick();
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = '0;
    bus.d_req_wdata = 32'h1234_5678; bus.d_req_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_req_ready = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !==
          {1'b1, 32'h0100_0200, 1'b1, 32'hDEAD_BEEF, 4'b0011})
        $display("FAIL store_hold_%0d: got %0b/%h/%0b/%h/%h want 1/01000200/1/deadbeef/3", i,
                 bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb);
      else pass_cnt++;
      tick();
    end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0;
    @(negedge clk);
    chk_cnt++; if ({bus.d_rsp_valid, bus.mem_req_valid} !== 2'b00) $display("FAIL store_wait: got %b want 00", {bus.d_rsp_valid, bus.mem_req_valid}); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.d_rsp_valid, bus.if_rsp_valid} !== 2'b10) $display("FAIL store_ack: got %b want 10", {bus.d_rsp_valid, bus.if_rsp_valid}); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (bus.d_rsp_valid !== 1'b0) $display("FAIL store_ack_len: got %0b want 0", bus.d_rsp_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0100_0008;
    tick();
    bus.if_req_valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (dbg_state !== WAIT) $display("FAIL rst_mid_in_wait: got %0d want 2", dbg_state); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0077;
    @(negedge clk);
    chk_cnt++; if (dbg_state !== IDLE) $display("FAIL rst_mid_idle: got %0d want 0", dbg_state); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    @(negedge clk);
    chk_cnt++;
    if ({bus.if_req_ready, bus.if_rsp_valid, bus.if_rsp_data, bus.d_req_ready, bus.d_rsp_valid,
         bus.d_rsp_data, bus.mem_req_valid, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb} !== '0)
      $display("FAIL rst_mid_outputs: got nonzero (if_rsp=%0b d_rsp=%0b) want all 0", bus.if_rsp_valid, bus.d_rsp_valid);
    else pass_cnt++;
    tick();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0100_000C;
    @(negedge clk);
    chk_cnt++; if (bus.if_req_ready !== 1'b1) $display("FAIL rst_mid_refetch: got %0b want 1", bus.if_req_ready); else pass_cnt++;
    tick();
    bus.if_req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.mem_req_valid, bus.mem_addr} !== {1'b1, 32'h0100_000C}) $display("FAIL rst_mid_req: got %0b/%h want 1/0100000c", bus.mem_req_valid, bus.mem_addr); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0033;
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b1, 32'h0000_0033}) $display("FAIL rst_mid_rsp: got %0b/%h want 1/00000033", bus.if_rsp_valid, bus.if_rsp_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_stray_rsp();
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0055;
    @(negedge clk);
    chk_cnt++; if (dbg_state !== IDLE) $display("FAIL stray_pre_state: got %0d want 0", dbg_state); else pass_cnt++;
    tick();
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    @(negedge clk);
    chk_cnt++; if ({bus.if_rsp_valid, bus.d_rsp_valid} !== 2'b00) $display("FAIL stray_no_pulse: got %b want 00", {bus.if_rsp_valid, bus.d_rsp_valid}); else pass_cnt++;
    chk_cnt++; if (dbg_state !== IDLE) $display("FAIL stray_state: got %0d want 0", dbg_state); else pass_cnt++;
  endtask

  // Scoreboard: expected grant order with both requesters held valid.
  task automatic test_back_to_back();
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    logic       rsp_next;
`ifdef MEM_ARB_RR_EN
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0100_0010;
    bus.d_req_valid  = 1'b1; bus.d_req_addr  = 32'h0100_0300; bus.d_req_we = 1'b0;
    for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
      @(negedge clk);
      if (bus.d_req_ready) got_q.push_back(1'b1);
      else if (bus.if_req_ready) got_q.push_back(1'b0);
      rsp_next = bus.mem_req_valid && bus.mem_req_ready;
      tick();
      bus.mem_rsp_valid = rsp_next;
    end
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      rsp_next = bus.mem_req_valid && bus.mem_req_ready;
      tick();
      bus.mem_rsp_valid = rsp_next;
    end
    bus.mem_rsp_valid = 1'b0;
    chk_cnt++; if (got_q.size() != 4) $display("FAIL b2b_count: got %0d want 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        chk_cnt++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_grant_%0d: got %0b want %0b (1=data)", i, got_q[i], exp_q[i]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_store_hold();
    test_reset_mid();
    test_stray_rsp();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
